// File: rtl/mcu_subsys_pkg.sv
// Shared definitions for the MCU peripheral responder: register offsets,
// CTRL/STATUS bit positions and the bus handshake state encoding.
package mcu_subsys_pkg;

    // Word offsets, compared against addr[7:2]
    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_TX_DATA = 6'h02;
    localparam logic [5:0] OFF_SCRATCH = 6'h03;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_FLUSH   = 2;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } resp_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mcu_subsys_sync_fifo.sv
// Single-clock FIFO with flush. Push into a full FIFO is accepted only when a
// pop happens on the same edge; flush overrides both push and pop.
module mcu_subsys_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mcu_subsys_periph_responder.sv
// Native memory-bus responder with programmable ack latency, a small register
// bank and a byte TX FIFO draining to a valid/ready stream.
module mcu_subsys_periph_responder
    import mcu_subsys_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    resp_state_e state_q;
    logic [3:0]  wait_cnt_q;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q;

    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        ovf_q, ovf_d;
    logic [31:0] scratch_q, scratch_d;

    logic          commit, push_req, flush, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [5:0]    rd_off;
    logic          rd_is_read;
    logic [31:0]   rd_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[31:8], mem_addr[1:0]};

    // In IDLE with zero wait states the read mux must see the live request.
    assign rd_off     = (state_q == ST_IDLE) ? mem_addr[7:2] : addr_q;
    assign rd_is_read = (state_q == ST_IDLE) ? (mem_wstrb == 4'b0000) : (wstrb_q == 4'b0000);

    always_comb begin
        rd_data = '0;
        case (rd_off)
            OFF_CTRL: begin
                rd_data[CTRL_EN]     = en_q;
                rd_data[CTRL_IRQ_EN] = irq_en_q;
            end
            OFF_STATUS: begin
                rd_data[STAT_EMPTY]             = fifo_empty;
                rd_data[STAT_FULL]              = fifo_full;
                rd_data[STAT_OVF]               = ovf_q;
                rd_data[STAT_CNT_LSB +: 8]      = {{(8-CW){1'b0}}, fifo_count};
            end
            OFF_SCRATCH: rd_data = scratch_q;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_ready_q <= 1'b0;
                    mem_rdata_q <= '0;
                    if (mem_valid) begin
                        addr_q  <= mem_addr[7:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        if (WAIT_STATES == 0) begin
                            state_q     <= ST_ACK;
                            mem_ready_q <= 1'b1;
                            mem_rdata_q <= rd_is_read ? rd_data : '0;
                        end else begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid) begin
                        state_q <= ST_IDLE;
                    end else if (wait_cnt_q == '0) begin
                        state_q     <= ST_ACK;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= rd_is_read ? rd_data : '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_q     <= ST_IDLE;
                    mem_ready_q <= 1'b0;
                    mem_rdata_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Writes take effect on the edge that ends the ACK cycle.
    assign commit   = (state_q == ST_ACK) && (wstrb_q != 4'b0000);
    assign fifo_pop = !fifo_empty && tx_ready;

    always_comb begin
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        scratch_d = scratch_q;
        flush     = 1'b0;
        push_req  = 1'b0;
        if (commit) begin
            case (addr_q)
                OFF_CTRL: if (wstrb_q[0]) begin
                    en_d     = wdata_q[CTRL_EN];
                    irq_en_d = wdata_q[CTRL_IRQ_EN];
                    flush    = wdata_q[CTRL_FLUSH];
                end
                OFF_STATUS: if (wstrb_q[0] && wdata_q[STAT_OVF]) ovf_d = 1'b0;
                OFF_TX_DATA: push_req = wstrb_q[0] && en_q;
                OFF_SCRATCH: scratch_d = strb_merge(scratch_q, wdata_q, wstrb_q);
                default: ;
            endcase
        end
        if (push_req && fifo_full && !fifo_pop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            scratch_q <= '0;
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            scratch_q <= scratch_d;
        end
    end

    mcu_subsys_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push_req),
        .din   (wdata_q[7:0]),
        .pop   (fifo_pop),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_head;
    assign irq       = irq_en_q && (fifo_empty || ovf_q);

endmodule

// File: tb/tb_mcu_subsys_periph_responder.sv
// Directed bench for the peripheral responder: bus latency, register bank,
// TX FIFO full/overflow/pass-through, flush and mid-transaction reset.
module tb_mcu_subsys_periph_responder;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    mcu_subsys_periph_responder #(
        .WAIT_STATES (1),
        .FIFO_DEPTH  (8)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction. Optionally raises tx_ready for the commit edge only.
    task automatic bus_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit pop_at_ack, output logic [31:0] rd, output int lat);
        bit got_ack;
        @(negedge sys_clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        lat       = 0;
        got_ack   = 1'b0;
        rd        = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            lat++;
            if (mem_ready) begin
                got_ack = 1'b1;
                break;
            end
            chk("rdata_wait", mem_rdata, 32'h0);
        end
        if (!got_ack) chk("ack_timeout", 32'(got_ack), 32'h1);
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        if (pop_at_ack) tx_ready = 1'b1;
        @(negedge sys_clk);
        if (pop_at_ack) tx_ready = 1'b0;
        chk("ready_low", 32'(mem_ready), 32'h0);
        chk("rdata_low", mem_rdata, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        bus_txn(a, d, s, 1'b0, rd, lat);
        chk("wr_rdata", rd, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus_txn(a, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [7:0]  exp_q[$];

        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        tx_ready  = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_ready", 32'(mem_ready), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_txd", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;

        // Latency: ready seen two edges after the accepting edge
        bus_txn(32'h0C, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk("lat_read", 32'(lat), 32'd2);
        chk("scratch_rst", rd, 32'h0);

        wr(32'h0C, 32'hA5A5_A5A5, 4'b0101);
        rd_chk("scratch_strb", 32'h0C, 32'h00A5_00A5);
        rd_chk("unmapped", 32'h40, 32'h0);
        rd_chk("txdata_rd", 32'h08, 32'h0);

        // Disabled: push dropped, no overflow
        wr(32'h08, 32'h99, 4'b0001);
        rd_chk("status_en0", 32'h04, 32'h0000_0001);

        wr(32'h00, 32'h1, 4'b0001);
        rd_chk("ctrl_en", 32'h00, 32'h1);
        for (int i = 0; i < 8; i++) begin
            wr(32'h08, 32'h10 + 32'(i), 4'b0001);
            exp_q.push_back(8'h10 + 8'(i));
        end
        rd_chk("status_full", 32'h04, 32'h0000_0802);
        chk("full_txv", 32'(tx_valid), 32'h1);
        chk("full_txd", 32'(tx_data), 32'h10);

        wr(32'h08, 32'hEE, 4'b0001);
        rd_chk("status_ovf", 32'h04, 32'h0000_0806);
        chk("ovf_txd", 32'(tx_data), 32'h10);

        wr(32'h04, 32'h4, 4'b0001);
        rd_chk("status_w1c", 32'h04, 32'h0000_0802);

        // Push while full with a same-edge pop
        bus_txn(32'h08, 32'h18, 4'b0001, 1'b1, rd, lat);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h18);
        rd_chk("status_pp", 32'h04, 32'h0000_0802);
        chk("irq_off", 32'(irq), 32'h0);

        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_v", 32'(tx_valid), 32'h1);
            chk("drain_d", 32'(tx_data), 32'(exp_q[i]));
            @(negedge sys_clk);
        end
        tx_ready = 1'b0;
        chk("drain_empty", 32'(tx_valid), 32'h0);

        // Flush with 3 queued bytes
        wr(32'h08, 32'h21, 4'b0001);
        wr(32'h08, 32'h22, 4'b0001);
        wr(32'h08, 32'h23, 4'b0001);
        rd_chk("status_3", 32'h04, 32'h0000_0300);
        wr(32'h00, 32'h7, 4'b0001);
        chk("flush_txv", 32'(tx_valid), 32'h0);
        chk("flush_irq", 32'(irq), 32'h1);
        rd_chk("status_flush", 32'h04, 32'h0000_0001);
        rd_chk("ctrl_readback", 32'h00, 32'h3);

        // Reset during WAIT of a TX_DATA write
        wr(32'h08, 32'h31, 4'b0001);
        wr(32'h08, 32'h32, 4'b0001);
        chk("pre_rst_txv", 32'(tx_valid), 32'h1);
        chk("pre_rst_irq", 32'(irq), 32'h0);
        @(negedge sys_clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h08;
        mem_wdata = 32'h55;
        mem_wstrb = 4'b0001;
        @(negedge sys_clk);
        chk("wait_ready", 32'(mem_ready), 32'h0);
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(negedge sys_clk);
        chk("mrst_ready", 32'(mem_ready), 32'h0);
        chk("mrst_rdata", mem_rdata, 32'h0);
        chk("mrst_txv", 32'(tx_valid), 32'h0);
        chk("mrst_txd", 32'(tx_data), 32'h0);
        chk("mrst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("mrst_noack", 32'(mem_ready), 32'h0);
        rd_chk("mrst_status", 32'h04, 32'h0000_0001);
        rd_chk("mrst_ctrl", 32'h00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
